// File: rtl/riscv_pkg.sv
// Shared RV32 types for the multiply/divide unit: op encoding (funct3), FSM states, width.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on operand
// magnitudes, sharing one 64-bit accumulator, a 6-bit counter and one adder/subtractor.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN     = riscv_pkg::XLEN,
  parameter bit          FAST_DIV = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + XLEN'(1)) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_if2(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + (2*XLEN)'(1)) : v;
  endfunction

  muldiv_state_e     state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  muldiv_op_e        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   a_mag_q, a_mag_d, b_mag_q, b_mag_d;
  logic              neg_q, neg_d, rneg_q, rneg_d;
  logic              special_q, special_d;
  logic [XLEN-1:0]   spec_res_q, spec_res_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rdo_q, rdo_d;

  // Operand decode at issue time
  muldiv_op_e      op_in;
  logic            is_div_in, sgn_a, sgn_b, an, bn, ovf_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in;

  assign op_in     = muldiv_op_e'(op);
  assign is_div_in = op[2];
  assign sgn_a     = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign sgn_b     = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  assign an        = sgn_a & rs1_val[XLEN-1];
  assign bn        = sgn_b & rs2_val[XLEN-1];
  assign a_mag_in  = neg_if(rs1_val, an);
  assign b_mag_in  = neg_if(rs2_val, bn);
  assign ovf_in    = ~op[0] && (rs1_val == INT_MIN) && (rs2_val == '1);

  // Shared adder: accumulates the multiplicand, or trial-subtracts the divisor
  logic            is_div;
  logic [XLEN:0]   add_x, add_y;
  logic [XLEN+1:0] add_res;
  logic [2*XLEN-1:0] step_acc;

  assign is_div  = op_q[2];
  assign add_x   = is_div ? acc_q[2*XLEN-1:XLEN-1] : {1'b0, acc_q[2*XLEN-1:XLEN]};
  assign add_y   = is_div ? ~{1'b0, b_mag_q} : {1'b0, (acc_q[0] ? a_mag_q : '0)};
  assign add_res = {1'b0, add_x} + {1'b0, add_y} + {{(XLEN+1){1'b0}}, is_div};

  always_comb begin
    if (is_div) begin
      if (add_res[XLEN+1]) step_acc = {add_res[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                 step_acc = {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      step_acc = {add_res[XLEN:0], acc_q[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   final_res;

  assign prod = neg_if2(acc_q, neg_q);

  always_comb begin
    final_res = '0;
    case (op_q)
      OP_MUL:                       final_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = neg_if(acc_q[XLEN-1:0], neg_q);
      OP_REM, OP_REMU:              final_res = neg_if(acc_q[2*XLEN-1:XLEN], rneg_q);
      default:                      final_res = '0;
    endcase
    if (special_q) final_res = spec_res_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    op_d       = op_q;
    rd_d       = rd_q;
    a_mag_d    = a_mag_q;
    b_mag_d    = b_mag_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    result_d   = result_q;
    rdo_d      = rdo_q;
    busy       = 1'b0;
    done       = 1'b0;
    result     = result_q;
    rd_out     = rdo_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d       = op_in;
          rd_d       = rd_in;
          a_mag_d    = a_mag_in;
          b_mag_d    = b_mag_in;
          neg_d      = an ^ bn;
          rneg_d     = an;
          special_d  = is_div_in && ((rs2_val == '0) || ovf_in);
          if (rs2_val == '0) spec_res_d = op[1] ? rs1_val : '1;
          else               spec_res_d = op[1] ? '0 : INT_MIN;
          acc_d      = {{XLEN{1'b0}}, (is_div_in ? a_mag_in : b_mag_in)};
          cnt_d      = '0;
          state_d    = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        // Fast special cases still spend one CALC cycle so done lands at issue+2
        if (FAST_DIV && special_q) begin
          state_d = DONE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        result   = final_res;
        rd_out   = rd_q;
        result_d = final_res;
        rdo_d    = rd_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      done     = 1'b0;
      result   = result_q;
      rd_out   = rdo_q;
      result_d = result_q;
      rdo_d    = rdo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      op_q       <= OP_MUL;
      rd_q       <= '0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      result_q   <= '0;
      rdo_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      a_mag_q    <= a_mag_d;
      b_mag_q    <= b_mag_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      result_q   <= result_d;
      rdo_q      <= rdo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model with a cycle-level
// expectation of busy/done/result/rd_out, plus directed literal cases and random traffic.
module tb_muldiv_unit;

  localparam bit FAST = 1'b1;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1_val = '0, rs2_val = '0, result;
  logic [4:0]  rd_in = '0, rd_out;
  logic        busy, done;

  muldiv_unit #(.XLEN(32), .FAST_DIV(FAST)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs1_val(rs1_val),
    .rs2_val(rs2_val), .rd_in(rd_in), .flush(flush), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0, failures = 0, cyc = 0;
  bit          chk_en = 1'b0;

  bit          pending = 1'b0;
  int unsigned start_cyc = 0, done_cyc = 0;
  logic [31:0] pend_res = '0, hold_res = '0;
  logic [4:0]  pend_rd = '0, hold_rd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, expv);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0] ua_u, ub_u, up;
    logic ovf;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    ua_u = {32'b0, a};
    ub_u = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = ua_u * ub_u; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && ((b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Reference timeline: an accepted request completes a fixed number of cycles later
  always @(posedge clk) begin
    if (reset) begin
      pending = 1'b0;
      hold_res = '0;
      hold_rd = '0;
    end else if (flush) begin
      pending = 1'b0;
    end else if (pending) begin
      if (cyc == done_cyc) begin
        hold_res = pend_res;
        hold_rd = pend_rd;
        pending = 1'b0;
      end
    end else if (start) begin
      pending = 1'b1;
      start_cyc = cyc;
      done_cyc = cyc + ((FAST && is_special(op, rs1_val, rs2_val)) ? 2 : 33);
      pend_res = ref_op(op, rs1_val, rs2_val);
      pend_rd = rd_in;
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_busy, exp_done;
      exp_busy = pending && (cyc > start_cyc) && (cyc < done_cyc);
      exp_done = pending && (cyc == done_cyc) && !flush;
      chk("busy", {31'b0, busy}, {31'b0, exp_busy});
      chk("done", {31'b0, done}, {31'b0, exp_done});
      chk("result", result, exp_done ? pend_res : hold_res);
      chk("rd_out", {27'b0, rd_out}, {27'b0, (exp_done ? pend_rd : hold_rd)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int unsigned s);
    step();
    start = 1'b1; op = o; rs1_val = a; rs2_val = b; rd_in = rd;
    s = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input logic [31:0] expv, input logic [4:0] rd,
                           input int unsigned s, input int unsigned lat);
    bit got = 1'b0;
    for (int k = 0; k < 45 && !got; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        chk(nm, result, expv);
        chk({nm, "_rd"}, {27'b0, rd_out}, {27'b0, rd});
        chk({nm, "_lat"}, cyc - s, lat);
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done_within_45", nm);
    end
  endtask

  task automatic run_lit(input string nm, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] expv,
                         input int unsigned lat);
    int unsigned s;
    issue(o, a, b, rd, s);
    wait_done(nm, expv, rd, s, lat);
  endtask

  initial begin
    int unsigned s, s2, dcount;
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s, s2, dcount;
    logic [2:0] sel;

    chk("model_mul", ref_op(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("model_mulhsu", ref_op(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    chk("model_div", ref_op(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("model_rem", ref_op(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", {27'b0, rd_out}, 32'd0);

    run_lit("mul",     3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 33);
    run_lit("mulh",    3'd1, 32'h8000_0000,  32'h8000_0000, 5'd2,  32'h4000_0000, 33);
    run_lit("mulhu",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 33);
    run_lit("mulhsu",  3'd2, 32'hFFFF_FFFF,  32'd2,         5'd4,  32'hFFFF_FFFF, 33);
    run_lit("div_ovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd5,  32'h8000_0000, 2);
    run_lit("rem_ovf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd6,  32'h0,         2);
    run_lit("divu_z",  3'd5, 32'd5,          32'd0,         5'd7,  32'hFFFF_FFFF, 2);
    run_lit("remu_z",  3'd7, 32'd5,          32'd0,         5'd0,  32'd5,         2);
    run_lit("div_neg", 3'd4, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFD, 33);
    run_lit("rem_neg", 3'd6, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFF, 33);
    run_lit("remu",    3'd7, 32'd100,        32'd7,         5'd10, 32'd2,         33);

    // Start pulses while busy and in the DONE cycle must be ignored
    issue(3'd0, 32'd5, 32'd6, 5'd11, s);
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      start = (k % 4 == 0) && (k <= 31);
      op = 3'd5; rs1_val = 32'd9; rs2_val = 32'd0; rd_in = 5'd12;
      @(negedge clk);
      if (done) begin
        dcount++;
        chk("ignore_res", result, 32'd30);
      end
    end
    start = 1'b0;
    chk("ignore_one_done", dcount, 32'd1);

    // Flush mid-DIVU, then a MUL issued in the first cycle after
    issue(3'd5, 32'd1000, 32'd3, 5'd13, s);
    while (cyc < s + 10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    start = 1'b1; op = 3'd0; rs1_val = 32'd123; rs2_val = 32'd456; rd_in = 5'd14;
    s2 = cyc;
    chk("flush_cyc", s2 - s, 32'd11);
    @(negedge clk);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    step();
    start = 1'b0;
    wait_done("mul_after_flush", 32'd56088, 5'd14, s2, 33);

    // Flush and start together: nothing starts
    step();
    start = 1'b1; flush = 1'b1; op = 3'd0; rs1_val = 32'd3; rs2_val = 32'd3; rd_in = 5'd15;
    step();
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", {31'b0, busy}, 32'd0);

    // Reset in the middle of a MULH
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd16, s);
    repeat (13) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_rd", {27'b0, rd_out}, 32'd0);
    repeat (40) step();

    // Random traffic, checked cycle by cycle against the model
    dcount = 0;
    for (int i = 0; i < 2500; i++) begin
      step();
      start = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 99) == 0);
      op = 3'($urandom);
      sel = 3'($urandom);
      rs1_val = (sel == 3'd0) ? 32'h8000_0000 : $urandom;
      rs2_val = (sel == 3'd1) ? 32'd0 : (sel == 3'd2) ? 32'hFFFF_FFFF :
                (sel == 3'd3) ? 32'($urandom_range(0, 15)) : $urandom;
      rd_in = 5'($urandom);
      @(negedge clk);
      if (done) dcount++;
    end
    start = 1'b0; flush = 1'b0;
    chk("rand_activity", {31'b0, (dcount >= 20)}, 32'd1);
    repeat (40) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
